unary_stream_ctrl: RTL
======================

Name: unary_stream_ctrl

Overview:
Sequencer for the shared sequence-counter array feeding the unary/stochastic number generators. Drives enable and clear of the shared counter, runs a programmable number of epochs of a programmable stream length, and tracks the counter-to-buffer pipeline latency. Emits a valid/last qualifier aligned with the buffered counter outputs. Sits between the layer scheduler (start/done handshake) and the counter array.

Parameters:
CWID, 10, counter width; stream length up to 2^CWID cycles
EWID, 8, epoch-count width
LAT, 1, cycles from counter enable to buffered counter output (0..4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
abort  in  1  synchronous abort; ends the run with no done
cfg_len  in  CWID+1  stream length in cycles per epoch (1..2^CWID)
cfg_epochs  in  EWID  epoch count (>=1)
stall  in  1  downstream back-pressure; freezes the counter
cnt_en  out  1  enable to the shared counter
cnt_clr  out  1  synchronous clear to the shared counter
stream_vld  out  1  buffered counter outputs valid this cycle
stream_last  out  1  last valid cycle of the current epoch
epoch_idx  out  EWID  index of the current epoch
epoch_done  out  1  one-cycle pulse at the end of each epoch
done  out  1  one-cycle pulse when all epochs complete
busy  out  1  high in every state except IDLE
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state IDLE; all outputs 0; epoch_idx 0; latched config 0; valid/last delay lines cleared.
- Accepted start in IDLE: cfg_len!=0 and cfg_epochs!=0. Latches cfg_len and cfg_epochs, clears epoch_idx, moves to CLEAR. Config is ignored for the rest of the run.
- Rejected start: cfg_len==0 or cfg_epochs==0. cfg_err pulses next cycle; state stays IDLE. A start outside IDLE is ignored silently.
- States:
  - IDLE: waits for an accepted start.
  - CLEAR: lasts 1 cycle; cnt_clr=1; clears the per-epoch cycle count cyc; goes to RUN.
  - RUN: cnt_en = ~stall; cyc increments on each cnt_en cycle. The cnt_en cycle with cyc==len-1 is the last; the next state is DRAIN, or END_EPOCH directly when LAT==0.
  - DRAIN: lasts exactly LAT cycles; cnt_en=0. In the final DRAIN cycle epoch_done=1. If epoch_idx==epochs-1 go to DONE; otherwise increment epoch_idx and go to CLEAR.
  - DONE: lasts 1 cycle; done=1; goes to IDLE.
- For LAT==0, epoch_done asserts in the same cycle as the last cnt_en, and the transition from that cycle applies the DRAIN exit rule.
- stream_vld is cnt_en delayed LAT cycles. stream_last is (cnt_en & cyc==len-1) delayed LAT cycles. Both use a registered shift line; LAT==0 means direct.
- Stall: affects RUN only. Stall bubbles propagate as stream_vld=0. Stall has no effect in CLEAR or DRAIN, and the drain count always advances.
- cyc width is CWID+1. Compare against len-1, so len=2^CWID gives the full counter wrap.
- Abort: takes priority over all transitions. From any non-IDLE state go to IDLE next cycle and flush both delay lines to 0 in that cycle. No epoch_done or done is produced. epoch_idx holds its value until the next accepted start.
- Simultaneous start and abort in IDLE: abort wins and start is ignored.
- Asynchronous reset mid-operation: immediate return to reset values, with no done.

Optional Feature:
- Macro: UNARY_STREAM_PERF_EN.
- Defined: adds output stall_cycles[31:0], the count of RUN cycles with stall=1. It clears on an accepted start, saturates at all-ones, and holds after done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package unary_ctrl_pkg:
  - state enum typedef (IDLE, CLEAR, RUN, DRAIN, DONE), 3-bit encoding;
  - LAT_MAX=4 constant.
- One sub-module, unary_vld_delay: a parameterised LAT-deep shift line with synchronous flush, instantiated for valid and for last.

Test Plan:
1. LAT=1, len=4, epochs=1, start at cycle 0, no stall -> cnt_clr@1; cnt_en@2-5; stream_vld@3-6; stream_last@6; epoch_done@6; done@7; busy@1-7.
2. As 1, with stall high @3 -> cnt_en@2,4,5,6; stream_vld@3,5,6,7; stream_last@7; done@8.
3. LAT=1, len=2, epochs=3 -> cnt_clr@1,5,9; epoch_done@4,8,12; epoch_idx 0/1/2; done@13.
4. cfg_len=0 start -> cfg_err pulse, busy stays 0. Start while busy -> no effect on timing.
5. Abort @3 during RUN -> IDLE@4, stream_vld=0@4, no done. Separately, rst_n low mid-RUN -> all outputs 0 immediately.
6. CWID=10, len=1024, LAT=0 -> 1024 cnt_en cycles, stream_last coincident with the last cnt_en. With UNARY_STREAM_PERF_EN and 5 stall cycles -> stall_cycles=5.

Source files
------------

// File: rtl/unary_ctrl_pkg.sv
// Shared types for the unary stream controller: FSM state encoding
// and the deepest counter-to-buffer latency the drain counter can cover.
package unary_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int LAT_MAX = 4;

endpackage

// File: rtl/unary_vld_delay.sv
// LAT-deep single-bit shift line with synchronous flush; LAT==0 is a wire.
// Ports: clk, rst_n (async, active-low), flush, din -> dout.
module unary_vld_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    if (LAT == 0) begin : g_direct
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, flush};
        assign dout = din;
    end else begin : g_line
        logic [LAT-1:0] line;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                line <= '0;
            end else if (flush) begin
                line <= '0;
            end else begin
                // Truncating cast drops the oldest bit.
                line <= LAT'({line, din});
            end
        end

        assign dout = line[LAT-1];
    end

endmodule

// File: rtl/unary_stream_ctrl.sv
// Sequencer for the shared unary/stochastic sequence-counter array.
// Ports: clk, rst_n, start/abort handshake, cfg_len/cfg_epochs, stall in;
//   cnt_en/cnt_clr to the counter, stream_vld/stream_last qualifiers,
//   epoch_idx, epoch_done, done, busy, cfg_err out.
// Build option UNARY_STREAM_PERF_EN adds stall_cycles[31:0] (RUN stalls).
module unary_stream_ctrl
    import unary_ctrl_pkg::*;
#(
    parameter int CWID = 10,
    parameter int EWID = 8,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CWID:0]   cfg_len,
    input  logic [EWID-1:0] cfg_epochs,
    input  logic            stall,
    output logic            cnt_en,
    output logic            cnt_clr,
    output logic            stream_vld,
    output logic            stream_last,
    output logic [EWID-1:0] epoch_idx,
    output logic            epoch_done,
    output logic            done,
    output logic            busy,
`ifdef UNARY_STREAM_PERF_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic            cfg_err
);

    localparam int DW = $clog2(LAT_MAX + 1);
    localparam logic [DW-1:0]   D_LAST = DW'(LAT - 1);
    localparam logic [DW-1:0]   D_ONE  = DW'(1);
    localparam logic [CWID:0]   C_ONE  = (CWID + 1)'(1);
    localparam logic [EWID-1:0] E_ONE  = EWID'(1);

    state_t          state;
    state_t          state_nx;
    logic [CWID:0]   len_q;
    logic [CWID:0]   cyc;
    logic [EWID-1:0] epochs_q;
    logic [EWID-1:0] epoch_q;
    logic [DW-1:0]   dcnt;

    logic cfg_ok;
    logic start_ok;
    logic start_bad;
    logic run_en;
    logic last_en;
    logic last_ep;
    logic epoch_end;
    logic flush;

    assign cfg_ok    = (cfg_len != '0) & (cfg_epochs != '0);
    // Abort wins over a simultaneous start, including its error pulse.
    assign start_ok  = (state == IDLE) & start & ~abort & cfg_ok;
    assign start_bad = (state == IDLE) & start & ~abort & ~cfg_ok;
    assign run_en    = (state == RUN) & ~stall;
    assign last_en   = run_en & (cyc == len_q - C_ONE);
    assign last_ep   = (epoch_q == epochs_q - E_ONE);
    // Without latency the epoch closes on its final counter cycle.
    assign epoch_end = (LAT == 0) ? last_en
                                  : ((state == DRAIN) & (dcnt == D_LAST));
    assign flush     = abort & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = RUN;
            end
            RUN: begin
                if (last_en) begin
                    if (LAT != 0)    state_nx = DRAIN;
                    else if (last_ep) state_nx = DONE;
                    else             state_nx = CLEAR;
                end
            end
            DRAIN: begin
                if (epoch_end) state_nx = last_ep ? DONE : CLEAR;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort) state_nx = IDLE;
    end

    always_comb begin
        cnt_clr    = (state == CLEAR);
        cnt_en     = run_en;
        busy       = (state != IDLE);
        epoch_done = epoch_end & ~abort;
        done       = (state == DONE) & ~abort;
        epoch_idx  = epoch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            epochs_q <= '0;
            epoch_q  <= '0;
            cyc      <= '0;
            dcnt     <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= start_bad;
            if (start_ok) begin
                len_q    <= cfg_len;
                epochs_q <= cfg_epochs;
                epoch_q  <= '0;
            end else if (epoch_end & ~last_ep & ~abort) begin
                epoch_q <= epoch_q + E_ONE;
            end
            if (state == CLEAR) begin
                cyc <= '0;
            end else if (run_en) begin
                cyc <= cyc + C_ONE;
            end
            if (state == DRAIN) begin
                dcnt <= dcnt + D_ONE;
            end else begin
                dcnt <= '0;
            end
        end
    end

`ifdef UNARY_STREAM_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if ((state == RUN) & stall & (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    unary_vld_delay #(
        .LAT (LAT)
    ) u_vld_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .din   (run_en),
        .dout  (stream_vld)
    );

    unary_vld_delay #(
        .LAT (LAT)
    ) u_last_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .din   (last_en),
        .dout  (stream_last)
    );

endmodule
